// File: rtl/csa_accum_seq_if.sv
// Operand/result stream bundle for csa_accum_seq.
// The slave modport is the accumulator side; the master modport is the producer/consumer side.
interface csa_accum_seq_if #(
    parameter int W     = 4,
    parameter int CNT_W = 4,
    parameter int OW    = W + CNT_W
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OW-1:0]    out_sum;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count
    );
endinterface

// File: rtl/csa_accum_seq.sv
// Multi-operand accumulator: folds a burst of operands into carry-save registers, then resolves to binary.
// Optional macro CSA_ACC_ABORT_EN adds an abort input that drops an in-flight burst.
module csa_accum_seq #(
    parameter int W     = 4,
    parameter int CNT_W = 4,
    parameter int OW    = W + CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    csa_accum_seq_if.slave     bus,
    output logic               busy
`ifdef CSA_ACC_ABORT_EN
    ,
    input  logic               abort
`endif
);
    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = '1;

    state_t           state;
    logic [OW-1:0]    sum_r;
    logic [OW-1:0]    carry_r;
    logic [CNT_W-1:0] count;
    logic             ready_r;
    logic             valid_r;

    logic [OW-1:0]    op;
    logic [OW-1:0]    csa_sum;
    logic [OW-1:0]    csa_carry;
    logic             accept;
    logic             handshake;
    logic             abort_req;

    assign op        = OW'(bus.in_data);
    assign csa_sum   = sum_r ^ carry_r ^ op;
    assign csa_carry = ((sum_r & carry_r) | (op & (sum_r ^ carry_r))) << 1;
    assign accept    = bus.in_valid & bus.in_ready;
    assign handshake = valid_r & bus.out_ready;

`ifdef CSA_ACC_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // ready_r holds the state-derived value; masking with rst keeps the port low while reset is applied
    assign bus.in_ready  = ready_r & ~rst;
    assign bus.out_valid = valid_r;
    assign bus.out_sum   = sum_r;
    assign bus.out_count = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sum_r   <= '0;
            carry_r <= '0;
            count   <= '0;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sum_r   <= op;
                        carry_r <= '0;
                        count   <= CNT_W'(1);
                        busy    <= 1'b1;
                        if (bus.in_last || MAX_CNT == CNT_W'(1)) begin
                            state   <= RESOLVE;
                            ready_r <= 1'b0;
                        end else begin
                            state   <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (abort_req) begin
                        state   <= IDLE;
                        sum_r   <= '0;
                        carry_r <= '0;
                        count   <= '0;
                        busy    <= 1'b0;
                    end else if (accept) begin
                        sum_r   <= csa_sum;
                        carry_r <= csa_carry;
                        count   <= count + CNT_W'(1);
                        // A burst that fills the counter ends here even without in_last
                        if (bus.in_last || (count + CNT_W'(1)) == MAX_CNT) begin
                            state   <= RESOLVE;
                            ready_r <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    if (abort_req) begin
                        state   <= IDLE;
                        sum_r   <= '0;
                        carry_r <= '0;
                        count   <= '0;
                        ready_r <= 1'b1;
                        busy    <= 1'b0;
                    end else if (carry_r == '0) begin
                        state   <= DONE;
                        valid_r <= 1'b1;
                    end else begin
                        sum_r   <= sum_r ^ carry_r;
                        carry_r <= (sum_r & carry_r) << 1;
                    end
                end
                DONE: begin
                    if (handshake) begin
                        state   <= IDLE;
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
